// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for the data memory / MMIO block: register offsets and TCTRL bit layout.
package data_mem_mmio_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [15:0] OFF_GPIO_OUT = 16'd0;
  localparam logic [15:0] OFF_GPIO_IN  = 16'd1;
  localparam logic [15:0] OFF_TCNT     = 16'd2;
  localparam logic [15:0] OFF_TCMP     = 16'd3;
  localparam logic [15:0] OFF_TCTRL    = 16'd4;

  localparam int unsigned TCTRL_EN   = 0;
  localparam int unsigned TCTRL_AUTO = 1;
  localparam int unsigned TCTRL_FLAG = 2;

  // Assemble the TCTRL read value; unused upper bits read as zero.
  function automatic logic [DATA_W-1:0] tctrl_pack(input logic en, input logic auto_rl,
                                                   input logic flag);
    logic [DATA_W-1:0] v;
    v = '0;
    v[TCTRL_EN]   = en;
    v[TCTRL_AUTO] = auto_rl;
    v[TCTRL_FLAG] = flag;
    return v;
  endfunction

endpackage

// File: rtl/data_mem_mmio_timer.sv
// 16-bit compare timer with one-shot / auto-reload modes and a sticky match flag.
module mmio_timer
  import data_mem_mmio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] writedata,
  input  logic              we_tcnt,
  input  logic              we_tcmp,
  input  logic              we_tctrl,
  output logic [DATA_W-1:0] tcnt,
  output logic [DATA_W-1:0] tcmp,
  output logic              en,
  output logic              auto_rl,
  output logic              flag,
  output logic              timer_irq
);

  // A core load of TCNT pre-empts both the match and the increment on that edge.
  logic match;
  assign match = en && (tcnt == tcmp) && !we_tcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt    <= '0;
      tcmp    <= '1;
      en      <= 1'b0;
      auto_rl <= 1'b0;
      flag    <= 1'b0;
    end else begin
      if (we_tcnt) begin
        tcnt <= writedata;
      end else if (match) begin
        if (auto_rl) tcnt <= '0;
      end else if (en) begin
        tcnt <= tcnt + DATA_W'(1);
      end

      if (we_tcmp) tcmp <= writedata;

      // A software write of EN overrides the one-shot auto-disable.
      if (we_tctrl) begin
        en      <= writedata[TCTRL_EN];
        auto_rl <= writedata[TCTRL_AUTO];
      end else if (match && !auto_rl) begin
        en <= 1'b0;
      end

      // Set beats write-1-to-clear on the same edge.
      if (match) begin
        flag <= 1'b1;
      end else if (we_tctrl && writedata[TCTRL_FLAG]) begin
        flag <= 1'b0;
      end
    end
  end

  assign timer_irq = flag;

endmodule

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM plus GPIO and compare-timer MMIO, downstream of the core memory port.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  input  logic [DATA_W-1:0] gpio_in,
  output logic [DATA_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] gpio_sync1;
  logic [DATA_W-1:0] gpio_sync2;
  logic [DATA_W-1:0] tcnt;
  logic [DATA_W-1:0] tcmp;
  logic              en;
  logic              auto_rl;
  logic              flag;

  logic              is_mmio;
  logic [DATA_W-1:0] off;
  logic              we_ram;
  logic              we_gpio;
  logic              we_tcnt;
  logic              we_tcmp;
  logic              we_tctrl;

  assign is_mmio  = (addr >= MMIO_BASE);
  assign off      = addr - MMIO_BASE;
  assign we_ram   = memwrite && !is_mmio;
  assign we_gpio  = memwrite && is_mmio && (off == OFF_GPIO_OUT);
  assign we_tcnt  = memwrite && is_mmio && (off == OFF_TCNT);
  assign we_tcmp  = memwrite && is_mmio && (off == OFF_TCMP);
  assign we_tctrl = memwrite && is_mmio && (off == OFF_TCTRL);

  // RAM is intentionally not reset; upper address bits alias.
  always_ff @(posedge clk) begin
    if (we_ram) mem[addr[DEPTH_LOG2-1:0]] <= writedata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      if (we_gpio) gpio_out <= writedata;
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .writedata (writedata),
    .we_tcnt   (we_tcnt),
    .we_tcmp   (we_tcmp),
    .we_tctrl  (we_tctrl),
    .tcnt      (tcnt),
    .tcmp      (tcmp),
    .en        (en),
    .auto_rl   (auto_rl),
    .flag      (flag),
    .timer_irq (timer_irq)
  );

  // Combinational read of current state; unmapped MMIO reads zero.
  always_comb begin
    readdata = '0;
    if (!is_mmio) begin
      readdata = mem[addr[DEPTH_LOG2-1:0]];
    end else begin
      case (off)
        OFF_GPIO_OUT: readdata = gpio_out;
        OFF_GPIO_IN:  readdata = gpio_sync2;
        OFF_TCNT:     readdata = tcnt;
        OFF_TCMP:     readdata = tcmp;
        OFF_TCTRL:    readdata = tctrl_pack(en, auto_rl, flag);
        default:      readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: directed timer/GPIO scenarios plus random traffic vs. a behavioural model.
module tb_data_mem_mmio;

  localparam logic [15:0] B = 16'hFF00;

  logic        clk;
  logic        reset;
  logic [15:0] addr;
  logic [15:0] writedata;
  logic        memwrite;
  logic [15:0] readdata;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic        timer_irq;

  data_mem_mmio #(.DEPTH_LOG2(8), .MMIO_BASE(16'hFF00)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [15:0] mram [int];
  logic [15:0] m_gpio, m_g1, m_g2, m_tcnt, m_tcmp;
  logic        m_en, m_auto, m_flag;

  task automatic model_reset();
    m_gpio = 16'h0; m_g1 = 16'h0; m_g2 = 16'h0;
    m_tcnt = 16'h0; m_tcmp = 16'hFFFF;
    m_en = 1'b0; m_auto = 1'b0; m_flag = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a < B) return mram[int'(a % 16'd256)];
    case (a - B)
      16'd0:   return m_gpio;
      16'd1:   return m_g2;
      16'd2:   return m_tcnt;
      16'd3:   return m_tcmp;
      16'd4:   return {13'd0, m_flag, m_auto, m_en};
      default: return 16'h0;
    endcase
  endfunction

  // One rising edge of the block, using the inputs present at that edge.
  task automatic model_edge(input logic [15:0] a, input logic [15:0] wd, input logic we);
    logic [15:0] n_tcnt;
    logic        n_en, n_flag, hit;
    if (!reset) begin
      model_reset();
      return;
    end
    m_g2 = m_g1;
    m_g1 = gpio_in;
    n_tcnt = m_tcnt; n_en = m_en; n_flag = m_flag; hit = 1'b0;
    if (we && a == B + 16'd2) begin
      n_tcnt = wd;
    end else if (m_en && m_tcnt == m_tcmp) begin
      hit = 1'b1;
      n_flag = 1'b1;
      if (m_auto) n_tcnt = 16'h0;
      else n_en = 1'b0;
    end else if (m_en) begin
      n_tcnt = m_tcnt + 16'd1;
    end
    if (we && a < B) mram[int'(a % 16'd256)] = wd;
    if (we && a == B) m_gpio = wd;
    if (we && a == B + 16'd3) m_tcmp = wd;
    if (we && a == B + 16'd4) begin
      n_en = wd[0];
      m_auto = wd[1];
      if (wd[2] && !hit) n_flag = 1'b0;
    end
    m_tcnt = n_tcnt; m_en = n_en; m_flag = n_flag;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int          kind;   // 0 readdata, 1 gpio_out, 2 timer_irq
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t sb[$];
  int total = 0;
  int bad = 0;

  always @(negedge clk) begin
    chk_t c;
    logic [15:0] act;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      case (c.kind)
        0:       act = readdata;
        1:       act = gpio_out;
        default: act = {15'd0, timer_irq};
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h want %h (addr=%h t=%0t)", c.name, act, c.exp, addr, $time);
      end
    end
  end

  task automatic expect_out(input int kind, input string nm);
    chk_t c;
    c.kind = kind;
    c.exp  = (kind == 1) ? m_gpio : {15'd0, m_flag};
    c.name = nm;
    sb.push_back(c);
  endtask

  // Drive one cycle; optionally queue the expected readdata for this cycle.
  task automatic step(input logic [15:0] a, input logic [15:0] wd, input logic we,
                      input bit chk, input string nm);
    chk_t c;
    addr = a; writedata = wd; memwrite = we;
    if (chk) begin
      c.kind = 0; c.exp = model_read(a); c.name = nm;
      sb.push_back(c);
    end
    @(posedge clk);
    model_edge(a, wd, we);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] wd);
    step(a, wd, 1'b1, 1'b0, "");
  endtask

  task automatic note_timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got no match within bound want match", nm);
  endtask

  initial begin
    logic [15:0] ra;
    logic        rwe;
    int          sel;

    reset = 1'b0; addr = 16'h0; writedata = 16'h0; memwrite = 1'b0; gpio_in = 16'h0;
    model_reset();
    @(posedge clk); #1;

    // reset state
    expect_out(1, "rst_gpio");
    expect_out(2, "rst_irq");
    step(B + 16'd3, 16'h0, 1'b0, 1'b1, "rst_tcmp");
    step(B + 16'd4, 16'h0, 1'b0, 1'b1, "rst_tctrl");
    reset = 1'b1;

    // RAM round trip and aliasing
    wr(16'h0012, 16'hBEEF);
    step(16'h0012, 16'h0, 1'b0, 1'b1, "ram_rd");
    step(16'h0112, 16'h0, 1'b0, 1'b1, "ram_alias");

    // GPIO
    wr(B, 16'hA5A5);
    expect_out(1, "gpio_out");
    step(B, 16'h0, 1'b0, 1'b1, "gpio_out_rd");
    gpio_in = 16'h1234;
    for (int i = 0; i < 3; i++) step(B + 16'd1, 16'h0, 1'b0, 1'b1, "gpio_in_sync");
    wr(B + 16'd1, 16'hFFFF);
    step(B + 16'd1, 16'h0, 1'b0, 1'b1, "gpio_in_ro");

    // one-shot timer
    wr(B + 16'd3, 16'd3);
    wr(B + 16'd2, 16'd0);
    wr(B + 16'd4, 16'd1);
    for (int i = 0; i < 6; i++) begin
      expect_out(2, "oneshot_irq");
      step(B + 16'd2, 16'h0, 1'b0, 1'b1, "oneshot_tcnt");
    end
    step(B + 16'd4, 16'h0, 1'b0, 1'b1, "oneshot_tctrl");
    wr(B + 16'd4, 16'd4);
    expect_out(2, "oneshot_clr_irq");
    step(B + 16'd4, 16'h0, 1'b0, 1'b1, "oneshot_clr");

    // auto-reload
    wr(B + 16'd3, 16'd2);
    wr(B + 16'd2, 16'd0);
    wr(B + 16'd4, 16'd3);
    for (int i = 0; i < 7; i++) step(B + 16'd2, 16'h0, 1'b0, 1'b1, "auto_tcnt");
    wr(B + 16'd4, 16'd7);
    for (int i = 0; i < 4 && !(m_en && m_tcnt == m_tcmp); i++)
      step(B + 16'd2, 16'h0, 1'b0, 1'b1, "auto_seek");
    if (!(m_en && m_tcnt == m_tcmp)) note_timeout("auto_seek");
    wr(B + 16'd4, 16'd7);
    expect_out(2, "auto_setwins_irq");
    step(B + 16'd4, 16'h0, 1'b0, 1'b1, "auto_setwins");
    wr(B + 16'd4, 16'd4);

    // wrap past FFFF
    wr(B + 16'd3, 16'd5);
    wr(B + 16'd2, 16'hFFFE);
    wr(B + 16'd4, 16'd1);
    for (int i = 0; i < 10; i++) begin
      expect_out(2, "wrap_irq");
      step(B + 16'd2, 16'h0, 1'b0, 1'b1, "wrap_tcnt");
    end
    wr(B + 16'd4, 16'd4);

    // TCNT write pre-empts a match
    wr(B + 16'd2, 16'd3);
    wr(B + 16'd4, 16'd1);
    for (int i = 0; i < 4 && !(m_en && m_tcnt == m_tcmp); i++)
      step(B + 16'd2, 16'h0, 1'b0, 1'b1, "prio_seek");
    if (!(m_en && m_tcnt == m_tcmp)) note_timeout("prio_seek");
    wr(B + 16'd2, 16'd0);
    expect_out(2, "prio_irq");
    step(B + 16'd2, 16'h0, 1'b0, 1'b1, "prio_tcnt");
    step(B + 16'd4, 16'h0, 1'b0, 1'b1, "prio_tctrl");
    wr(B + 16'd4, 16'd4);

    // unmapped MMIO
    wr(B + 16'd7, 16'h1234);
    step(B + 16'd7, 16'h0, 1'b0, 1'b1, "unmapped_ff07");
    step(B + 16'd5, 16'h0, 1'b0, 1'b1, "unmapped_ff05");
    for (int k = 0; k < 5; k++) step(B + 16'(k), 16'h0, 1'b0, 1'b1, "mmio_intact");

    // random traffic
    for (int i = 0; i < 300; i++) begin
      sel = int'($urandom_range(0, 3));
      if (sel < 2) ra = 16'($urandom_range(0, 16'h03FF));
      else ra = B + 16'($urandom_range(0, 7));
      rwe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) gpio_in = 16'($urandom);
      if ((i % 8) == 0) begin
        expect_out(1, "rnd_gpio");
        expect_out(2, "rnd_irq");
      end
      step(ra, 16'($urandom), rwe, (ra >= B) || mram.exists(int'(ra % 16'd256)), "rnd_rd");
    end
    wr(B + 16'd4, 16'd4);

    // asynchronous reset mid-count
    wr(B, 16'h5A5A);
    wr(B + 16'd3, 16'h0100);
    wr(B + 16'd2, 16'h0010);
    wr(B + 16'd4, 16'd1);
    for (int i = 0; i < 3; i++) step(B + 16'd2, 16'h0, 1'b0, 1'b1, "arst_pre");
    reset = 1'b0;
    model_reset();
    expect_out(1, "arst_gpio");
    expect_out(2, "arst_irq");
    step(B + 16'd2, 16'h0, 1'b0, 1'b1, "arst_tcnt");
    step(B + 16'd3, 16'h0, 1'b0, 1'b1, "arst_tcmp");
    step(B + 16'd4, 16'h0, 1'b0, 1'b1, "arst_tctrl");
    reset = 1'b1;
    step(B + 16'd2, 16'h0, 1'b0, 1'b1, "arst_release");

    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
